input_arbiter: RTL and testbench
================================

Name: input_arbiter

Overview:
- Owns the player-control path between the PS/2 keyboard decoder, joystick 0 and joystick 1, and the game core's single set of control lines.
- Grants control to one source at a time, locks the grant until the owner has been idle for a frame-counted hold time, and applies cabinet rotation and opposing-direction cancellation.
- Generates a frame-timed coin pulse.
- Sits in the top level between the keyboard/mist_io outputs and the ladybugt button inputs.

Parameters:
- HOLD_FRAMES, 30: idle frames of the owner before the grant is released.
- COIN_FRAMES, 4: length of the coin pulse in frames.

Ports:
- clk_sys  in  1  system clock
- res_n  in  1  asynchronous active-low reset
- vblank  in  1  core vblank; each rising edge is one frame tick
- rotate  in  1  1 = rotated control mapping (status[2])
- kbjoy  in  10  keyboard: [0]fire [1]start1 [2]start2 [3]coin [4]up [5]down [6]left [7]right [8]bomb
- joystick_0  in  8  [0]right [1]left [2]down [3]up [4]fire [5]bomb
- joystick_1  in  8  same layout as joystick_0
- m_up, m_down, m_left, m_right  out  1 each  arbitrated directions, active-high
- m_fire, m_bomb  out  1 each  arbitrated buttons
- m_start1, m_start2  out  1 each  registered kbjoy[1], kbjoy[2]
- m_coin  out  1  coin pulse
- owner  out  2  0 = KBD, 1 = JOY0, 2 = JOY1, 3 = NONE

Behaviour:
- Reset (res_n = 0, asynchronous):
  - All m_* outputs = 0; owner = 3.
  - Hold and coin counters = 0.
  - vblank edge register = 0.
  - State = IDLE.
- Input stage:
  - All inputs are registered once.
  - Each source is normalised to vec = {bomb, fire, right, left, down, up}.
  - active(s) = |vec(s).
- Frame tick: vblank_reg & ~vblank_prev, one cycle wide.
- Latency: an input change appears on the outputs 2 clk_sys cycles later. An owner change and its data switch take effect on the same cycle.
- State machine:
  - IDLE: if any source is active, grant the highest-priority active source (KBD > JOY0 > JOY1) and go to OWNED. Otherwise owner stays 3 and all arbitrated outputs are 0.
  - OWNED(s):
    - Outputs follow vec(s).
    - While active(s), hold_cnt = 0.
    - On each frame tick with s idle, hold_cnt increments; it saturates at HOLD_FRAMES.
    - When hold_cnt = HOLD_FRAMES:
      - If another source is active that cycle, grant the highest-priority one directly and clear hold_cnt.
      - Else go to IDLE.
    - Activity on non-owners before expiry is ignored.
  - If the owner becomes active again in the same cycle as expiry, it keeps the grant (reload wins).
- Direction cleanup, applied after selection:
  - Rotation. rotate = 0: pass through. rotate = 1: up←right, down←left, left←up, right←down.
  - Opposing-direction cancellation is applied after rotation: up & down → both 0; left & right → both 0.
- Coin:
  - A rising edge of registered kbjoy[3] while coin_cnt = 0 sets m_coin = 1 and coin_cnt = COIN_FRAMES.
  - Each frame tick decrements coin_cnt; m_coin drops on the cycle coin_cnt reaches 0.
  - Edges during a pulse are ignored.
  - Holding coin produces a single pulse.
- Counter widths: $clog2(param+1) bits, unsigned, no wrap.
- Start buttons are not arbitrated and are independent of owner.

Test Plan:
- Release reset with no inputs -> owner = 3, all m_* = 0 for 1000 cycles.
- joystick_0[3] = 1 at cycle N -> owner = 1 and m_up = 1 at N+2. Then kbjoy[7] = 1 while joy0 is held -> m_right stays 0, owner stays 1.
- Release joystick_0, hold kbjoy[7] -> owner switches to 0 on the 30th vblank rising edge after release; m_right = 1 the same cycle.
- rotate = 1, kbjoy[4] = 1 (up) -> m_left = 1, m_up = 0. Then kbjoy[4] and kbjoy[5] both 1 -> m_left = 0, m_right = 0.
- kbjoy[3] held for 10 frames -> m_coin high for exactly 4 frame ticks, one pulse. A second press after the pulse ends -> a second pulse.
- Reset asserted mid-grant and mid-coin-pulse -> outputs 0 and owner = 3 immediately (asynchronously). After release with inputs idle -> still IDLE.

Source files
------------

// File: rtl/input_arbiter.sv
// Player-control arbiter: grants the keyboard or one of two joysticks
// ownership of the core's control lines, holds the grant until the owner
// has been idle for HOLD_FRAMES frames, applies cabinet rotation and
// opposing-direction cancellation, and generates a frame-timed coin pulse.
//
// state  | meaning
// IDLE   | no source owns the controls, owner = 3, arbitrated outputs 0
// OWNED  | owner_q drives the controls until its idle hold time expires
module input_arbiter #(
    parameter int HOLD_FRAMES = 30,
    parameter int COIN_FRAMES = 4
) (
    input  logic       clk_sys,
    input  logic       res_n,
    input  logic       vblank,
    input  logic       rotate,
    input  logic [9:0] kbjoy,
    input  logic [7:0] joystick_0,
    input  logic [7:0] joystick_1,
    output logic       m_up,
    output logic       m_down,
    output logic       m_left,
    output logic       m_right,
    output logic       m_fire,
    output logic       m_bomb,
    output logic       m_start1,
    output logic       m_start2,
    output logic       m_coin,
    output logic [1:0] owner
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam int COIN_W = $clog2(COIN_FRAMES + 1);

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t            state, state_nxt;
    logic [1:0]        owner_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [COIN_W-1:0] coin_cnt;

    logic              vblank_reg, vblank_prev, rotate_reg, coin_prev;
    logic [8:0]        kb_reg;
    logic [5:0]        j0_reg, j1_reg;

    logic              frame_tick, coin_edge, owner_act, expire;
    logic [5:0]        vec_kb, vec_j0, vec_j1, sel_vec;
    logic [2:0]        act;
    logic [1:0]        prio;
    logic              r_up, r_down, r_left, r_right;

    // Bits of the input buses that carry nothing for this core.
    logic              unused_bits;
    assign unused_bits = ^{kbjoy[9], joystick_0[7:6], joystick_1[7:6]};

    // Input stage: every input registered once, plus edge-detect history.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            vblank_reg  <= 1'b0;
            vblank_prev <= 1'b0;
            rotate_reg  <= 1'b0;
            kb_reg      <= '0;
            j0_reg      <= '0;
            j1_reg      <= '0;
            coin_prev   <= 1'b0;
        end else begin
            vblank_reg  <= vblank;
            vblank_prev <= vblank_reg;
            rotate_reg  <= rotate;
            kb_reg      <= kbjoy[8:0];
            j0_reg      <= joystick_0[5:0];
            j1_reg      <= joystick_1[5:0];
            coin_prev   <= kb_reg[3];
        end
    end

    assign frame_tick = vblank_reg & ~vblank_prev;
    assign coin_edge  = kb_reg[3] & ~coin_prev;

    // Normalised layout: {bomb, fire, right, left, down, up}.
    assign vec_kb = {kb_reg[8], kb_reg[0], kb_reg[7], kb_reg[6], kb_reg[5], kb_reg[4]};
    assign vec_j0 = {j0_reg[5], j0_reg[4], j0_reg[0], j0_reg[1], j0_reg[2], j0_reg[3]};
    assign vec_j1 = {j1_reg[5], j1_reg[4], j1_reg[0], j1_reg[1], j1_reg[2], j1_reg[3]};
    assign act    = {|vec_j1, |vec_j0, |vec_kb};

    // Fixed priority KBD > JOY0 > JOY1; 3 when nobody is active.
    always_comb begin
        prio = 2'd3;
        if (act[0])      prio = 2'd0;
        else if (act[1]) prio = 2'd1;
        else if (act[2]) prio = 2'd2;
    end

    // Grant state machine. Expiry is taken on the tick that would make the
    // counter reach HOLD_FRAMES, so the hand-over lands on that frame edge.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        hold_nxt  = hold_cnt;
        owner_act = 1'b0;
        expire    = 1'b0;
        case (owner)
            2'd0:    owner_act = act[0];
            2'd1:    owner_act = act[1];
            2'd2:    owner_act = act[2];
            default: owner_act = 1'b0;
        endcase
        case (state)
            S_IDLE: begin
                hold_nxt  = '0;
                owner_nxt = prio;
                if (|act) state_nxt = S_OWNED;
            end
            S_OWNED: begin
                expire = (hold_cnt == HOLD_W'(HOLD_FRAMES)) ||
                         (frame_tick && hold_cnt == HOLD_W'(HOLD_FRAMES - 1));
                if (owner_act) begin
                    hold_nxt = '0;
                end else if (expire) begin
                    hold_nxt  = '0;
                    owner_nxt = prio;
                    if (!(|act)) state_nxt = S_IDLE;
                end else if (frame_tick) begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                owner_nxt = 2'd3;
                hold_nxt  = '0;
            end
        endcase
    end

    // Data of the next owner, then rotation, then opposing cancellation.
    always_comb begin
        case (owner_nxt)
            2'd0:    sel_vec = vec_kb;
            2'd1:    sel_vec = vec_j0;
            2'd2:    sel_vec = vec_j1;
            default: sel_vec = '0;
        endcase
        if (rotate_reg) begin
            r_up    = sel_vec[3];
            r_down  = sel_vec[2];
            r_left  = sel_vec[0];
            r_right = sel_vec[1];
        end else begin
            r_up    = sel_vec[0];
            r_down  = sel_vec[1];
            r_left  = sel_vec[2];
            r_right = sel_vec[3];
        end
    end

    // Grant state and arbitrated outputs move together, so owner and data
    // switch on the same cycle.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state    <= S_IDLE;
            owner    <= 2'd3;
            hold_cnt <= '0;
            m_up     <= 1'b0;
            m_down   <= 1'b0;
            m_left   <= 1'b0;
            m_right  <= 1'b0;
            m_fire   <= 1'b0;
            m_bomb   <= 1'b0;
            m_start1 <= 1'b0;
            m_start2 <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
            m_up     <= r_up & ~r_down;
            m_down   <= r_down & ~r_up;
            m_left   <= r_left & ~r_right;
            m_right  <= r_right & ~r_left;
            m_fire   <= sel_vec[4];
            m_bomb   <= sel_vec[5];
            m_start1 <= kb_reg[1];
            m_start2 <= kb_reg[2];
        end
    end

    // Coin pulse: armed by a press edge only when idle, counts frames down.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            coin_cnt <= '0;
        end else if (coin_edge && coin_cnt == '0) begin
            coin_cnt <= COIN_W'(COIN_FRAMES);
        end else if (frame_tick && coin_cnt != '0) begin
            coin_cnt <= coin_cnt - COIN_W'(1);
        end
    end

    assign m_coin = (coin_cnt != '0);

endmodule

// File: tb/tb_input_arbiter.sv
// Directed bench for input_arbiter: stimulus queues expected output words
// tagged with the cycle they are due; a monitor compares them on negedge.
module tb_input_arbiter;

    logic       clk_sys = 1'b0;
    logic       res_n = 1'b0;
    logic       vblank = 1'b0;
    logic       rotate = 1'b0;
    logic [9:0] kbjoy = '0;
    logic [7:0] joystick_0 = '0;
    logic [7:0] joystick_1 = '0;
    logic       m_up, m_down, m_left, m_right, m_fire, m_bomb;
    logic       m_start1, m_start2, m_coin;
    logic [1:0] owner;

    input_arbiter #(.HOLD_FRAMES(30), .COIN_FRAMES(4)) dut (
        .clk_sys    (clk_sys),
        .res_n      (res_n),
        .vblank     (vblank),
        .rotate     (rotate),
        .kbjoy      (kbjoy),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .m_up       (m_up),
        .m_down     (m_down),
        .m_left     (m_left),
        .m_right    (m_right),
        .m_fire     (m_fire),
        .m_bomb     (m_bomb),
        .m_start1   (m_start1),
        .m_start2   (m_start2),
        .m_coin     (m_coin),
        .owner      (owner)
    );

    always #5 clk_sys = ~clk_sys;

    localparam logic [8:0] U  = 9'h100;
    localparam logic [8:0] D  = 9'h080;
    localparam logic [8:0] L  = 9'h040;
    localparam logic [8:0] R  = 9'h020;
    localparam logic [8:0] F  = 9'h010;
    localparam logic [8:0] B  = 9'h008;
    localparam logic [8:0] S1 = 9'h004;
    localparam logic [8:0] S2 = 9'h002;
    localparam logic [8:0] C  = 9'h001;

    typedef struct {
        int          cyc;
        string       name;
        logic [10:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [10:0] got;

    assign got = {owner, m_up, m_down, m_left, m_right, m_fire, m_bomb,
                  m_start1, m_start2, m_coin};

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Monitor: pops every expectation whose cycle has arrived.
    always @(negedge clk_sys) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s: not sampled at cycle %0d (now %0d)", e.name, e.cyc, cyc);
            end else if (got !== e.val) begin
                failures++;
                $display("FAIL %s: cycle %0d got owner=%0d bits=%b, want owner=%0d bits=%b",
                         e.name, cyc, got[10:9], got[8:0], e.val[10:9], e.val[8:0]);
            end
        end
    end

    task automatic expect_out(input int d, input string n, input logic [1:0] o,
                              input logic [8:0] m);
        sb.push_back('{cyc + d, n, {o, m}});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic vb_pulse();
        vblank = 1'b1;
        tick(4);
        vblank = 1'b0;
        tick(4);
    endtask

    initial begin
        tick(3);
        res_n = 1'b1;
        expect_out(0, "reset_state", 2'd3, 9'h000);

        // Idle with no inputs for 1000 cycles.
        for (int i = 0; i < 10; i++) begin
            tick(100);
            expect_out(0, "idle_no_input", 2'd3, 9'h000);
        end

        // Joystick 0 up: grant after two cycles.
        joystick_0[3] = 1'b1;
        expect_out(1, "grant_latency", 2'd3, 9'h000);
        expect_out(2, "joy0_up", 2'd1, U);
        tick(2);
        kbjoy[7] = 1'b1;
        expect_out(2, "kb_ignored", 2'd1, U);
        tick(3);

        // Release joystick 0, keyboard right keeps asking.
        joystick_0 = '0;
        expect_out(2, "owner_idle", 2'd1, 9'h000);
        tick(3);
        for (int i = 0; i < 29; i++) vb_pulse();
        expect_out(0, "hold_29_frames", 2'd1, 9'h000);
        vblank = 1'b1;
        expect_out(1, "hold_30_pre", 2'd1, 9'h000);
        expect_out(2, "kb_grant_30", 2'd0, R);
        tick(4);
        vblank = 1'b0;
        tick(4);

        // Rotation and cancellation.
        rotate = 1'b1;
        kbjoy = 10'h010;
        expect_out(2, "rot_up_to_left", 2'd0, L);
        tick(3);
        kbjoy = 10'h030;
        expect_out(2, "rot_cancel", 2'd0, 9'h000);
        tick(3);
        kbjoy = 10'h080;
        expect_out(2, "rot_right_to_up", 2'd0, U);
        tick(3);
        rotate = 1'b0;
        kbjoy = 10'h030;
        expect_out(2, "cancel_up_down", 2'd0, 9'h000);
        tick(3);
        kbjoy = 10'h0C0;
        expect_out(2, "cancel_left_right", 2'd0, 9'h000);
        tick(3);
        kbjoy = 10'h107;
        expect_out(2, "buttons_starts", 2'd0, F | B | S1 | S2);
        tick(3);

        // Coin held for 10 frames: single 4-frame pulse.
        kbjoy = 10'h009;
        expect_out(2, "coin_on", 2'd0, F | C);
        tick(4);
        for (int i = 0; i < 3; i++) begin
            vb_pulse();
            expect_out(0, "coin_hold", 2'd0, F | C);
        end
        vblank = 1'b1;
        expect_out(1, "coin_last_frame", 2'd0, F | C);
        expect_out(2, "coin_drop", 2'd0, F);
        tick(4);
        vblank = 1'b0;
        tick(4);
        for (int i = 0; i < 6; i++) vb_pulse();
        expect_out(0, "coin_single_pulse", 2'd0, F);
        kbjoy = 10'h001;
        tick(3);
        kbjoy = 10'h009;
        expect_out(2, "coin_second", 2'd0, F | C);
        tick(3);

        // Asynchronous reset mid-grant and mid-coin.
        @(posedge clk_sys);
        #2;
        res_n = 1'b0;
        expect_out(0, "async_reset", 2'd3, 9'h000);
        tick(1);
        kbjoy = '0;
        tick(3);
        res_n = 1'b1;
        tick(5);
        expect_out(0, "post_reset_idle", 2'd3, 9'h000);
        tick(2);

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            failures += sb.size();
            $display("FAIL drain: %0d expectations never sampled", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
